// File: rtl/alu_pkg.sv
// Shared ALU function codes, arbiter FSM states and the hamming-distance helper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_AND     = 4'b0001;
  localparam logic [3:0] ALU_XOR     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0101;
  localparam logic [3:0] ALU_LUI     = 4'b0110;
  localparam logic [3:0] ALU_SRL     = 4'b0111;
  localparam logic [3:0] ALU_HAMD    = 4'b1001;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 32; i++) cnt = cnt + 6'(x[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts move b by a[4:0], undefined codes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] s,
  output logic        z
);

  always_comb begin
    s = '0;
    case (aluc)
      ALU_ADD:  s = a + b;
      ALU_SUB:  s = a - b;
      ALU_AND:  s = a & b;
      ALU_OR:   s = a | b;
      ALU_XOR:  s = a ^ b;
      ALU_LUI:  s = {b[15:0], 16'h0000};
      ALU_SLL:  s = b << a[4:0];
      ALU_SRL:  s = b >> a[4:0];
      ALU_SRA:  s = $signed(b) >>> a[4:0];
      ALU_HAMD: s = {26'd0, popcount32(a ^ b)};
      default:  s = '0;
    endcase
  end

  assign z = (s == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between two req/ack clients: IDLE grants and
// latches operands, EXEC evaluates and stores results, DONE pulses the ack.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [3:0]  aluc0,
  input  logic [3:0]  aluc1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] s0,
  output logic [31:0] s1,
  output logic        z0,
  output logic        z1,
  output logic        err0,
  output logic        err1,
  output logic        busy
);

  state_t      state, state_next;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_c;
  logic        gnt, last;
  logic        grant, sel;
  logic [31:0] alu_s;
  logic        alu_z;

  alu u_alu (
    .a    (op_a),
    .b    (op_b),
    .aluc (op_c),
    .s    (alu_s),
    .z    (alu_z)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    // Under contention the port not served last wins; otherwise the lone requester.
    sel        = (req0 && req1) ? ~last : req1;
    case (state)
      IDLE: if (req0 || req1) begin
        grant      = 1'b1;
        state_next = EXEC;
      end
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      gnt   <= 1'b0;
      last  <= ~RESET_PRIO;
      s0    <= '0;
      s1    <= '0;
      z0    <= 1'b0;
      z1    <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        op_a <= sel ? a1 : a0;
        op_b <= sel ? b1 : b0;
        op_c <= sel ? aluc1 : aluc0;
        gnt  <= sel;
      end
      if (state == EXEC) begin
        last <= gnt;
        if (gnt) begin
          s1   <= alu_s;
          z1   <= alu_z;
          err1 <= (op_c == ALU_ILLEGAL);
        end else begin
          s0   <= alu_s;
          z0   <= alu_z;
          err0 <= (op_c == ALU_ILLEGAL);
        end
      end
    end
  end

  assign ack0 = (state == DONE) && !gnt;
  assign ack1 = (state == DONE) && gnt;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: per-scenario tasks with hand-computed expectations.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  aluc0 = '0, aluc1 = '0;
  logic        ack0, ack1, z0, z1, err0, err1, busy;
  logic [31:0] s0, s1;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arb #(.RESET_PRIO(1'b0)) dut (
    .clock (clock), .reset (reset),
    .req0  (req0),  .req1  (req1),
    .a0    (a0),    .b0    (b0),    .a1 (a1), .b1 (b1),
    .aluc0 (aluc0), .aluc1 (aluc1),
    .ack0  (ack0),  .ack1  (ack1),
    .s0    (s0),    .s1    (s1),
    .z0    (z0),    .z1    (z1),
    .err0  (err0),  .err1  (err1),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL reset_ack1 got %b want 0", ack1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({s0, s1} !== 64'd0) begin n_bad++; $display("FAIL reset_s got %h %h want 0 0", s0, s1); end
    n_cmp++; if ({z0, z1, err0, err1} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {z0, z1, err0, err1}); end
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd5; aluc0 = ALU_ADD;
    tick();
    n_cmp++; if ({ack0, ack1, busy} !== 3'b001) begin n_bad++; $display("FAIL single_c1 ack0/ack1/busy got %b want 001", {ack0, ack1, busy}); end
    tick();
    n_cmp++; if ({ack0, ack1, busy} !== 3'b101) begin n_bad++; $display("FAIL single_c2 ack0/ack1/busy got %b want 101", {ack0, ack1, busy}); end
    n_cmp++; if (s0 !== 32'd12) begin n_bad++; $display("FAIL single_s0 got %h want 0000000c", s0); end
    n_cmp++; if ({z0, err0} !== 2'b00) begin n_bad++; $display("FAIL single_z0_err0 got %b want 00", {z0, err0}); end
    req0 = 1'b0;
    tick();
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_bad++; $display("FAIL single_c3 ack0/ack1/busy got %b want 000", {ack0, ack1, busy}); end
    n_cmp++; if (s0 !== 32'd12) begin n_bad++; $display("FAIL single_hold_s0 got %h want 0000000c", s0); end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1; a0 = 32'd9; b0 = 32'd9; aluc0 = ALU_SUB;
    req1 = 1'b1; a1 = 32'hFFFF0000; b1 = 32'd0; aluc1 = ALU_HAMD;
    for (int c = 1; c <= 8; c++) begin
      logic [2:0] exp;
      tick();
      exp = {(c == 2 || c == 8), (c == 5), (c % 3 != 0)};
      n_cmp++; if ({ack0, ack1, busy} !== exp) begin n_bad++; $display("FAIL contend_c%0d ack0/ack1/busy got %b want %b", c, {ack0, ack1, busy}, exp); end
      if (c == 2) begin
        n_cmp++; if ({s0, z0} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL contend_s0_z0 got %h %b want 00000000 1", s0, z0); end
      end
      if (c == 5) begin
        n_cmp++; if (s1 !== 32'd16) begin n_bad++; $display("FAIL contend_s1 got %h want 00000010", s1); end
      end
      if (c == 8) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick();
  endtask

  task automatic test_held();
    req1 = 1'b1; a1 = 32'd4; b1 = 32'h80000000; aluc1 = ALU_SRA;
    tick(); tick();
    n_cmp++; if (ack1 !== 1'b1) begin n_bad++; $display("FAIL held_ack1 got %b want 1", ack1); end
    n_cmp++; if ({s1, z1} !== {32'hF8000000, 1'b0}) begin n_bad++; $display("FAIL held_sra_s1 got %h %b want f8000000 0", s1, z1); end
    req1 = 1'b0;
    tick();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; aluc0 = ALU_ADD;
    tick(); tick();
    n_cmp++; if ({ack0, s0} !== {1'b1, 32'd2}) begin n_bad++; $display("FAIL held_port0 ack0/s0 got %b %h want 1 00000002", ack0, s0); end
    n_cmp++; if ({s1, z1, ack1} !== {32'hF8000000, 2'b00}) begin n_bad++; $display("FAIL held_s1_kept got %h %b %b want f8000000 0 0", s1, z1, ack1); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; aluc0 = ALU_ILLEGAL;
    tick(); tick();
    n_cmp++; if ({ack0, s0, z0, err0} !== {1'b1, 32'd0, 2'b11}) begin n_bad++; $display("FAIL illegal got ack0=%b s0=%h z0=%b err0=%b want 1 00000000 1 1", ack0, s0, z0, err0); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL illegal_err1 got %b want 0", err1); end
    req0 = 1'b0;
    tick();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; aluc0 = ALU_OR;
    tick(); tick();
    n_cmp++; if ({ack0, s0, z0, err0} !== {1'b1, 32'd3, 2'b00}) begin n_bad++; $display("FAIL illegal_clear got ack0=%b s0=%h z0=%b err0=%b want 1 00000003 0 0", ack0, s0, z0, err0); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    logic [31:0] va [9], vb [9], vs [9];
    logic [3:0]  vc [9];
    va = '{32'hFF00FF00, 32'hAAAA5555, 32'd4,  32'd8,        32'd0,        32'd3,        32'hF,    32'd5,   32'hFFFFFFFF};
    vb = '{32'h0F0F0F0F, 32'hFFFF0000, 32'd1,  32'h80000000, 32'h00001234, 32'd5,        32'h1,    32'd5,   32'd1};
    vc = '{ALU_AND,      ALU_XOR,      ALU_SLL, ALU_SRL,     ALU_LUI,      ALU_SUB,      ALU_HAMD, 4'b1000, ALU_ADD};
    vs = '{32'h0F000F00, 32'h55555555, 32'h10, 32'h00800000, 32'h12340000, 32'hFFFFFFFE, 32'd3,    32'd0,   32'd0};
    for (int i = 0; i < 9; i++) begin
      req1 = 1'b1; a1 = va[i]; b1 = vb[i]; aluc1 = vc[i];
      tick(); tick();
      n_cmp++;
      if ({ack1, s1, z1, err1} !== {1'b1, vs[i], (vs[i] == 32'd0), 1'b0}) begin
        n_bad++;
        $display("FAIL ops_%0d got ack1=%b s1=%h z1=%b err1=%b want 1 %h %b 0", i, ack1, s1, z1, err1, vs[i], (vs[i] == 32'd0));
      end
      req1 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midop();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd5; aluc0 = ALU_ADD;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midop_busy_exec got %b want 1", busy); end
    reset = 1'b1; req0 = 1'b0;
    tick();
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_bad++; $display("FAIL midop_ack_busy got %b want 000", {ack0, ack1, busy}); end
    n_cmp++; if ({s0, s1, z0, z1, err0, err1} !== 68'd0) begin n_bad++; $display("FAIL midop_cleared got %h %h %b want all zero", s0, s1, {z0, z1, err0, err1}); end
    reset = 1'b0;
    req0 = 1'b1; a0 = 32'hF0; b0 = 32'hFF; aluc0 = ALU_XOR;
    req1 = 1'b1; a1 = 32'd4;  b1 = 32'd1;  aluc1 = ALU_SLL;
    for (int c = 1; c <= 5; c++) begin
      logic [1:0] exp;
      tick();
      exp = {(c == 2), (c == 5)};
      n_cmp++; if ({ack0, ack1} !== exp) begin n_bad++; $display("FAIL midop_prio_c%0d ack0/ack1 got %b want %b", c, {ack0, ack1}, exp); end
      if (c == 2) begin
        n_cmp++; if (s0 !== 32'h0F) begin n_bad++; $display("FAIL midop_s0 got %h want 0000000f", s0); end
        req0 = 1'b0;
      end
      if (c == 5) begin
        n_cmp++; if (s1 !== 32'h10) begin n_bad++; $display("FAIL midop_s1 got %h want 00000010", s1); end
        req1 = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_operand_stability();
    req0 = 1'b1; a0 = 32'd10; b0 = 32'd3; aluc0 = ALU_SUB;
    tick();
    a0 = 32'd100; b0 = 32'd50;
    tick();
    n_cmp++; if ({ack0, s0} !== {1'b1, 32'd7}) begin n_bad++; $display("FAIL stable_s0 got ack0=%b s0=%h want 1 00000007", ack0, s0); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; aluc0 = ALU_ADD;
    tick(); tick();
    n_cmp++; if ({ack0, s0} !== {1'b1, 32'd3}) begin n_bad++; $display("FAIL b2b_first got ack0=%b s0=%h want 1 00000003", ack0, s0); end
    a0 = 32'd10;
    tick();
    n_cmp++; if ({ack0, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle ack0/busy got %b want 00", {ack0, busy}); end
    tick();
    n_cmp++; if ({ack0, busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_exec ack0/busy got %b want 01", {ack0, busy}); end
    tick();
    n_cmp++; if ({ack0, s0} !== {1'b1, 32'd12}) begin n_bad++; $display("FAIL b2b_second got ack0=%b s0=%h want 1 0000000c", ack0, s0); end
    req0 = 1'b0;
    tick();
    n_cmp++; if ({ack0, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_end ack0/busy got %b want 00", {ack0, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_held();
    test_illegal();
    test_ops();
    test_reset_midop();
    test_operand_stability();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
